// File: rtl/fifo_sync_core.sv
// Single-clock FIFO core with registered read data and registered occupancy flags.
// Optional sticky overflow/underflow outputs are enabled by defining FIFO_OVF_UDF_EN.
module fifo_sync_core #(
    parameter int unsigned DATA_W       = 128,
    parameter int unsigned DEPTH        = 16,
    parameter int unsigned ALM_FULL_TH  = 2,
    parameter int unsigned ALM_EMPTY_TH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wren,
    input  logic              i_rden,
    input  logic [DATA_W-1:0] i_wrdata,
    output logic              o_full,
    output logic              o_alm_full,
    output logic              o_empty,
    output logic              o_alm_empty,
    output logic [DATA_W-1:0] o_rddata
`ifdef FIFO_OVF_UDF_EN
    ,
    output logic              o_overflow,
    output logic              o_underflow
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    localparam logic [CW-1:0] FULL_LVL      = CW'(DEPTH);
    localparam logic [CW-1:0] ALM_FULL_LVL  = CW'(DEPTH - ALM_FULL_TH);
    localparam logic [CW-1:0] ALM_EMPTY_LVL = CW'(ALM_EMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_nxt;
    logic              wr_acc;
    logic              rd_acc;

    assign wr_acc = i_wren & ~o_full;
    assign rd_acc = i_rden & ~o_empty;

    always_comb begin
        count_nxt = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
        endcase
    end

    // Storage is deliberately left out of reset; reset only blocks the write.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem[wr_ptr] <= i_wrdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            o_rddata    <= '0;
            o_full      <= 1'b0;
            o_alm_full  <= 1'b0;
            o_empty     <= 1'b1;
            o_alm_empty <= 1'b1;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (rd_acc) begin
                o_rddata <= mem[rd_ptr];
                rd_ptr   <= rd_ptr + AW'(1);
            end
            count <= count_nxt;
            // Flags track post-edge occupancy so they line up with the pointers.
            o_full      <= (count_nxt == FULL_LVL);
            o_alm_full  <= (count_nxt >= ALM_FULL_LVL);
            o_empty     <= (count_nxt == '0);
            o_alm_empty <= (count_nxt <= ALM_EMPTY_LVL);
        end
    end

`ifdef FIFO_OVF_UDF_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            o_overflow  <= 1'b0;
            o_underflow <= 1'b0;
        end else begin
            if (i_wren && o_full) begin
                o_overflow <= 1'b1;
            end
            if (i_rden && o_empty && !i_wren) begin
                o_underflow <= 1'b1;
            end
        end
    end
`else
    // Illegal requests are silently dropped or ignored.
`endif

endmodule
